// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared opcode, state and datapath-select codes for the multicycle MIPS control
package mips_mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_TRAP   = 4'd11
  } mc_state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL = 2'b11;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS sequencer with memory handshake, illegal trap and retire counter
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             BNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  mc_state_t        state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!is_supported(opcode)) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else if (opcode == OP_R) begin
          state_d = ST_EXEC;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_d = ST_MEMADR;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          state_d = ST_BRANCH;
        end else begin
          state_d = ST_ADDIEX;
        end
      end
      // The IR still holds the opcode, so LW/SW is re-decoded here.
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_BRANCH: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Moore decode of state; FETCH's IRWrite/PCWrite follow mem_ready, and rst blanks everything.
  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    BNE      = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        ST_DECODE: ALUSrcB = SRCB_IMM_SL;
        ST_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        ST_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_SUB;
          Branch  = 1'b1;
          PCSrc   = PCSRC_ALUOUT;
          BNE     = (opcode == OP_BNE);
        end
        ST_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, Branch, BNE, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, illegal;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] retired;
  logic [3:0] state;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] exp_retired = 4'd0;

  logic [5:0] strobes;
  logic [9:0] sels;
  assign strobes = {PCWrite, Branch, IRWrite, MemRead, MemWrite, RegWrite};
  assign sels    = {BNE, IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .BNE(BNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (strobes !== 6'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 000000", strobes); end
    n_checks++; if (sels !== 10'b0) begin n_fail++; $display("FAIL reset_sels: got %b want 0", sels); end
    n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    exp_retired = 4'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
    opcode = OP_ADDI;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_checks++; if (RegWrite !== (i == 3)) begin n_fail++; $display("FAIL addi_regwrite[%0d]: got %b want %b", i, RegWrite, (i == 3)); end
      if (i == 0) begin
        n_checks++; if (strobes !== 6'b101100) begin n_fail++; $display("FAIL fetch_strobes: got %b want 101100", strobes); end
        n_checks++; if (sels !== 10'b0000001000) begin n_fail++; $display("FAIL fetch_sels: got %b want 0000001000", sels); end
      end
      if (i == 2) begin
        n_checks++; if (sels !== 10'b0000110000) begin n_fail++; $display("FAIL addiex_sels: got %b want 0000110000", sels); end
      end
      @(negedge clk);
    end
    exp_retired = exp_retired + 4'd1;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL addi_end_state: got %0d want 0", state); end
    n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL addi_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  task automatic test_lw_wait();
    logic [3:0] st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OP_LW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      if (st[i] == 4'd3) begin
        n_checks++; if ({MemRead, IorD, RegWrite} !== 3'b110) begin n_fail++; $display("FAIL lw_memrd[%0d]: got %b want 110", i, {MemRead, IorD, RegWrite}); end
        n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL lw_wait_retired[%0d]: got %0d want %0d", i, retired, exp_retired); end
      end
      if (st[i] == 4'd4) begin
        n_checks++; if ({MemtoReg, RegWrite, RegDst, MemRead} !== 4'b1100) begin n_fail++; $display("FAIL lw_memwb: got %b want 1100", {MemtoReg, RegWrite, RegDst, MemRead}); end
      end
      @(negedge clk);
    end
    exp_retired = exp_retired + 4'd1;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL lw_end_state: got %0d want 0", state); end
    n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL lw_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  task automatic test_sw_fetch_wait();
    logic [3:0] st [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic       rdy [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    opcode = OP_SW;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++; if (state !== st[i]) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      if (i == 0) begin
        n_checks++; if (strobes !== 6'b000100) begin n_fail++; $display("FAIL fetch_wait_strobes: got %b want 000100", strobes); end
      end
      if (st[i] == 4'd5) begin
        n_checks++; if ({MemWrite, IorD, MemRead} !== 3'b110) begin n_fail++; $display("FAIL sw_memwr[%0d]: got %b want 110", i, {MemWrite, IorD, MemRead}); end
      end
      @(negedge clk);
    end
    exp_retired = exp_retired + 4'd1;
    #1;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL sw_end_state: got %0d want 0", state); end
    n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL sw_retired: got %0d want %0d", retired, exp_retired); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2] = '{OP_BNE, OP_BEQ};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1;
        if (i == 1) begin
          n_checks++; if (sels !== 10'b0000011000) begin n_fail++; $display("FAIL decode_sels: got %b want 0000011000", sels); end
        end
        if (i == 2) begin
          n_checks++; if (state !== 4'd8) begin n_fail++; $display("FAIL br_state[%0d]: got %0d want 8", k, state); end
          n_checks++; if ({Branch, BNE, PCSrc, ALUOp, ALUSrcA, ALUSrcB} !== {1'b1, (k == 0), 1'b1, 2'b01, 1'b1, 2'b00}) begin
            n_fail++; $display("FAIL br_outputs[%0d]: got %b want %b", k, {Branch, BNE, PCSrc, ALUOp, ALUSrcA, ALUSrcB}, {1'b1, (k == 0), 1'b1, 2'b01, 1'b1, 2'b00});
          end
        end
        @(negedge clk);
      end
      exp_retired = exp_retired + 4'd1;
      #1;
      n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL br_end_state[%0d]: got %0d want 0", k, state); end
      n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL br_retired[%0d]: got %0d want %0d", k, retired, exp_retired); end
    end
  endtask

  task automatic test_reset_in_memwr();
    opcode = OP_SW;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++; if ({state, MemWrite} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL memwr_wait: got state %0d MemWrite %b want 5 1", state, MemWrite); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL async_memwrite: got %b want 0", MemWrite); end
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL async_state: got %0d want 0", state); end
    n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL async_retired: got %0d want 0", retired); end
    n_checks++; if (strobes !== 6'b0) begin n_fail++; $display("FAIL async_strobes: got %b want 0", strobes); end
    exp_retired = 4'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (state !== 4'd11) begin n_fail++; $display("FAIL trap_state: got %0d want 11", state); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL trap_illegal: got %b want 1", illegal); end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      n_checks++; if ({state, strobes} !== {4'd11, 6'b0}) begin n_fail++; $display("FAIL trap_hold[%0d]: got state %0d strobes %b want 11 000000", i, state, strobes); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL trap_retired: got %0d want %0d", retired, exp_retired); end
    rst = 1'b1;
    #1;
    n_checks++; if ({illegal, state} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL trap_clear: got illegal %b state %0d want 0 0", illegal, state); end
    exp_retired = 4'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    opcode = OP_R;
    mem_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) begin
        #1;
        if (n == 0 && i == 2) begin
          n_checks++; if ({state, sels} !== {4'd6, 10'b0000100100}) begin n_fail++; $display("FAIL exec: got state %0d sels %b want 6 0000100100", state, sels); end
        end
        if (n == 0 && i == 3) begin
          n_checks++; if ({state, RegDst, RegWrite, MemtoReg} !== {4'd7, 3'b110}) begin n_fail++; $display("FAIL aluwb: got state %0d bits %b want 7 110", state, {RegDst, RegWrite, MemtoReg}); end
        end
        @(negedge clk);
      end
      exp_retired = exp_retired + 4'd1;
      #1;
      n_checks++; if (retired !== exp_retired) begin n_fail++; $display("FAIL wrap_retired[%0d]: got %0d want %0d", n, retired, exp_retired); end
    end
    n_checks++; if (retired !== 4'd0) begin n_fail++; $display("FAIL wrap_final: got %0d want 0", retired); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branch();
    test_reset_in_memwr();
    test_illegal();
    test_back_to_back_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle variant of the MIPS core. It decodes the latched instruction opcode and steps the shared datapath through fetch, decode, execute, memory and writeback. The datapath is one ALU, one unified instruction/data memory port, the register file and the PC. It sits beside the datapath top level and supports the same instruction set as the single-cycle core: R-type, LW, SW, BEQ, BNE, ADDI. It adds a memory-ready handshake, an illegal-opcode trap and a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory access completes this cycle; sampled only in FETCH, MEMRD and MEMWR
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load; datapath loads the PC when Branch & (BNE ? ~zero : zero)
- BNE  out  1  inverts the zero condition
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 1 = rd, 0 = rt
- MemtoReg  out  1  writeback data select: 1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A operand select: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU B operand select: 00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm << 2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded; feeds the existing alu_control block
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut
- illegal  out  1  sticky flag; set on an unsupported opcode
- retired  out  CNT_W  count of completed instructions
- state  out  4  current state, for debug

## Operation
State encoding (4-bit):
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, TRAP=11.

Control outputs are Moore outputs, decoded from state only. Any signal not listed for a state is 0.

State behaviour and transitions:
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0. IRWrite=PCWrite=mem_ready; this is the only Mealy term.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 or 000101 → BRANCH; 001000 → ADDIEX; any other → TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for LW, MEMWR for SW; opcode is still held in the IR.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Next is FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=1, BNE=(opcode==000101).
  - Next is FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1. Next is FETCH.
- TRAP: all strobes 0 and illegal=1. Stays in TRAP until rst.

Retired-instruction counter:
- retired increments by 1 on the clock edge that leaves MEMWB, ALUWB, BRANCH, ADDIWB, or MEMWR with mem_ready=1.
- It wraps modulo 2^CNT_W.
- It never increments on entering TRAP.

## Timing
Instruction latency, in cycles, with mem_ready held at 1:
- LW: 5
- SW: 4
- R-type: 4
- ADDI: 4
- BEQ/BNE: 3

Each cycle that mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Handshake rules:
- Memory strobes stay asserted and steady until the cycle in which mem_ready=1.
- A mem_ready pulse in any other state is ignored.

Reset:
- While rst=1: state=FETCH, retired=0, illegal=0, and all strobes (PCWrite, Branch, IRWrite, MemRead, MemWrite, RegWrite) are forced to 0 combinationally. Select outputs are 0.
- Reset mid-instruction, including during MEMWR wait, aborts at once: MemWrite drops in the same cycle, with no partial writeback.
- After rst deasserts, the first rising edge executes FETCH.

## Structure
- Package mips_mc_pkg holds:
  - the opcode constants (R, LW, SW, BEQ, BNE, ADDI);
  - the 4-bit state encoding;
  - the ALUOp, ALUSrcB and PCSrc codes.
- The existing single-cycle control_unit uses the same opcode constants.
- This is a single module. No sub-module is needed: the output decode is a case on state, next to the state register.

## Test plan
- ADDI: opcode=001000, mem_ready=1 → states 0,1,9,10,0; RegWrite=1 only in state 10; retired 0→1.
- LW with memory wait: opcode=100011, mem_ready low for 2 cycles in MEMRD → 7 cycles total; MemRead and IorD steady through the wait; MemtoReg=1 with RegWrite=1 in MEMWB.
- BNE: opcode=000101 → BRANCH with Branch=1, BNE=1, PCSrc=1, ALUOp=01; back in FETCH after 3 cycles.
- Illegal opcode: opcode=111111 → TRAP after DECODE; illegal=1; every strobe 0 for 20 cycles; retired unchanged; rst clears illegal.
- Asynchronous reset: rst asserted during a MEMWR wait → MemWrite=0 in the same cycle; state=0, retired=0.
- Counter wrap: CNT_W=4 with 16 back-to-back R-type instructions → retired wraps 15→0.
